// File: rtl/ex_alu_stage.sv
// EX stage of a 5-stage pipeline: combinational ALU feeding the EX/MEM pipeline register.
// Supports stall (hold), flush (bubble) and a sticky flag for unsupported ALU operations.
module ex_alu_stage #(
  parameter int WIDTH = 16,
  parameter int REGW  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] store_data,
  input  logic [REGW-1:0]  wr_reg,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             err_sticky,
  output logic [WIDTH-1:0] out_store_data,
  output logic [REGW-1:0]  out_wr_reg,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic [WIDTH-1:0] store_data;
    logic [REGW-1:0]  wr_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } ex_mem_t;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             legal;
  ex_mem_t          load_entry;
  ex_mem_t          entry_q;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    legal   = 1'b1;
    case (alu_ctl)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      // Signed compare rather than the sign of diff, so slt stays correct when a-b wraps.
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: legal = 1'b0;
    endcase
  end

  // An illegal op yields result 0 (hence zero=1) and no architectural side effects.
  always_comb begin
    load_entry = '0;
    if (in_valid) begin
      load_entry.valid      = 1'b1;
      load_entry.result     = legal ? alu_res : '0;
      load_entry.zero       = legal ? (alu_res == '0) : 1'b1;
      load_entry.overflow   = legal & alu_ovf;
      load_entry.illegal    = ~legal;
      load_entry.store_data = store_data;
      load_entry.wr_reg     = wr_reg;
      load_entry.reg_write  = legal & reg_write;
      load_entry.mem_read   = legal & mem_read;
      load_entry.mem_write  = legal & mem_write;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
    end else if (flush) begin
      entry_q <= '0;
    end else if (!stall) begin
      entry_q <= load_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (!flush && !stall && in_valid && !legal) begin
      err_sticky <= 1'b1;
    end
  end

  assign out_valid      = entry_q.valid;
  assign result         = entry_q.result;
  assign zero           = entry_q.zero;
  assign overflow       = entry_q.overflow;
  assign illegal        = entry_q.illegal;
  assign out_store_data = entry_q.store_data;
  assign out_wr_reg     = entry_q.wr_reg;
  assign out_reg_write  = entry_q.reg_write;
  assign out_mem_read   = entry_q.mem_read;
  assign out_mem_write  = entry_q.mem_write;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model of the EX/MEM register.
module tb_ex_alu_stage;

  localparam int WIDTH = 16;
  localparam int REGW  = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [2:0]       alu_ctl;
  logic [WIDTH-1:0] op_a, op_b, store_data;
  logic [REGW-1:0]  wr_reg;
  logic             reg_write, mem_read, mem_write, stall, flush;
  logic             out_valid, zero, overflow, illegal, err_sticky;
  logic [WIDTH-1:0] result, out_store_data;
  logic [REGW-1:0]  out_wr_reg;
  logic             out_reg_write, out_mem_read, out_mem_write;

  ex_alu_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .alu_ctl(alu_ctl),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .wr_reg(wr_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .stall(stall), .flush(flush), .out_valid(out_valid), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal), .err_sticky(err_sticky),
    .out_store_data(out_store_data), .out_wr_reg(out_wr_reg),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the EX/MEM register should hold after each edge.
  logic             m_valid, m_zero, m_ovf, m_ill, m_sticky, m_rw, m_mr, m_mw;
  logic [WIDTH-1:0] m_result, m_store;
  logic [REGW-1:0]  m_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int sval(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_result = '0; m_zero = 0; m_ovf = 0; m_ill = 0;
    m_store = '0; m_wr = '0; m_rw = 0; m_mr = 0; m_mw = 0;
  endtask

  // Applies the edge rules using plain signed/unsigned integer arithmetic.
  task automatic model_update();
    int sa, sb, full;
    bit ok;
    logic [WIDTH-1:0] r;
    bit ov;
    sa = sval(op_a); sb = sval(op_b);
    ok = 1; ov = 0; r = '0;
    case (alu_ctl)
      3'b010: begin full = sa + sb; r = WIDTH'((int'(op_a) + int'(op_b)) % 65536);
                    ov = (full > 32767) || (full < -32768); end
      3'b110: begin full = sa - sb; r = WIDTH'((int'(op_a) - int'(op_b) + 65536) % 65536);
                    ov = (full > 32767) || (full < -32768); end
      3'b000: r = op_a & op_b;
      3'b001: r = op_a | op_b;
      3'b111: r = (sa < sb) ? 1 : 0;
      default: ok = 0;
    endcase
    if (reset) begin
      model_bubble();
      m_sticky = 0;
    end else if (flush) begin
      model_bubble();
    end else if (stall) begin
      // hold everything
    end else if (!in_valid) begin
      model_bubble();
    end else begin
      m_valid = 1;
      m_result = ok ? r : '0;
      m_zero = (m_result == 0);
      m_ovf = ok && ov;
      m_ill = !ok;
      m_store = store_data; m_wr = wr_reg;
      m_rw = ok && reg_write; m_mr = ok && mem_read; m_mw = ok && mem_write;
      if (!ok) m_sticky = 1;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    #1;
    model_update();
    check(tag,
      {21'b0, out_valid, result, zero, overflow, illegal, err_sticky, out_store_data,
       out_wr_reg, out_reg_write, out_mem_read, out_mem_write},
      {21'b0, m_valid, m_result, m_zero, m_ovf, m_ill, m_sticky, m_store,
       m_wr, m_rw, m_mr, m_mw});
  endtask

  task automatic idle();
    reset = 0; in_valid = 0; alu_ctl = 3'b010; op_a = '0; op_b = '0;
    store_data = '0; wr_reg = '0; reg_write = 0; mem_read = 0; mem_write = 0;
    stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [2:0] ctl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    idle();
    in_valid = 1; alu_ctl = ctl; op_a = a; op_b = b;
    store_data = WIDTH'($urandom); wr_reg = REGW'($urandom);
    reg_write = 1; mem_read = $urandom_range(0, 1); mem_write = $urandom_range(0, 1);
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    m_sticky = 0;
    model_bubble();
    idle();
    reset = 1;
    tick("reset");
    check("reset_valid", out_valid, 0);
    check("reset_sticky", err_sticky, 0);

    issue(3'b010, 16'h7FFF, 16'h0001); tick("add_ovf");
    check("add_ovf_result", result, 16'h8000);
    check("add_ovf_flag", overflow, 1);
    check("add_ovf_zero", zero, 0);
    check("add_ovf_valid", out_valid, 1);

    issue(3'b110, 16'h1234, 16'h1234); tick("sub_eq");
    check("sub_eq_result", result, 16'h0000);
    check("sub_eq_zero", zero, 1);
    check("sub_eq_ovf", overflow, 0);
    issue(3'b111, 16'h8000, 16'h0001); tick("slt_neg");
    check("slt_neg_result", result, 16'h0001);

    issue(3'b000, 16'hF0F0, 16'h0FF0); tick("and");
    check("and_result", result, 16'h00F0);
    issue(3'b001, 16'hF0F0, 16'h0FF0); tick("or");
    check("or_result", result, 16'hFFF0);

    issue(3'b010, 16'd2, 16'd3); tick("load5");
    for (int i = 0; i < 3; i++) begin
      issue(3'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      stall = 1;
      tick("stall_hold");
      check("stall_result", result, 16'd5);
      check("stall_valid", out_valid, 1);
    end
    flush = 1; tick("stall_flush");
    check("stall_flush_valid", out_valid, 0);
    check("stall_flush_result", result, 0);

    issue(3'b101, 16'h1111, 16'h2222); tick("illegal");
    check("illegal_flag", illegal, 1);
    check("illegal_rw", out_reg_write, 0);
    check("illegal_result", result, 0);
    check("illegal_sticky", err_sticky, 1);
    idle(); tick("sticky_idle");
    check("sticky_persist", err_sticky, 1);
    reset = 1; tick("sticky_reset");
    check("sticky_cleared", err_sticky, 0);
    issue(3'b101, 16'h1111, 16'h2222); flush = 1; tick("illegal_flushed");
    check("flushed_sticky", err_sticky, 0);

    issue(3'b011, 16'h0, 16'h0); tick("illegal2");
    issue(3'b010, 16'h0100, 16'h0020); tick("pre_stall");
    stall = 1; reset = 1; tick("reset_in_stall");
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_result", result, 0);
    check("rst_stall_sticky", err_sticky, 0);

    for (int i = 0; i < 600; i++) begin
      issue(3'($urandom), pick_operand(), pick_operand());
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      reg_write = $urandom_range(0, 1);
      tick("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
